// File: rtl/adder_if.sv
// +---------------------------------------------------------------------------+
// | adder_if : operand/result bundle for the registered CLA adder.            |
// | isOdd is present only when ADDER_ISODD_EN is defined.                     |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

interface adder_if #(
    parameter int W = 32
);
    logic [W-1:0] inA;
    logic [W-1:0] inB;
    logic [W:0]   out;
`ifdef ADDER_ISODD_EN
    logic         isOdd;

    modport master (output inA, output inB, input out, input isOdd);
    modport slave  (input inA, input inB, output out, output isOdd);
`else
    modport master (output inA, output inB, input out);
    modport slave  (input inA, input inB, output out);
`endif
endinterface

`default_nettype wire

// File: rtl/adder.sv
// +---------------------------------------------------------------------------+
// | adder : W-bit unsigned adder, W/4 rippled 4-bit CLA groups, 1-cycle       |
// | registered (W+1)-bit sum. Optional parity flag under ADDER_ISODD_EN.      |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module adder #(
    parameter int W = 32
) (
    input  wire logic clk,
    input  wire logic rst_n,
    adder_if.slave    bus
);
    localparam int c_NGRP = W / 4;

    logic [c_NGRP:0] grp_carry;
    logic [W-1:0]    sum;
    logic [W:0]      out_d;
    logic [W:0]      out_q;

    assign grp_carry[0] = 1'b0;

    for (genvar gi = 0; gi < c_NGRP; gi++) begin : g_cla
        logic [3:0] g;
        logic [3:0] p;
        logic [3:0] c;
        logic       grp_g;
        logic       grp_p;

        assign g = bus.inA[4*gi +: 4] & bus.inB[4*gi +: 4];
        assign p = bus.inA[4*gi +: 4] ^ bus.inB[4*gi +: 4];

        // Bit carries inside the group are looked ahead from the group carry-in.
        assign c[0] = grp_carry[gi];
        assign c[1] = g[0] | (p[0] & c[0]);
        assign c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c[0]);
        assign c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
                    | (p[2] & p[1] & p[0] & c[0]);

        assign grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
                     | (p[3] & p[2] & p[1] & g[0]);
        assign grp_p = &p;

        assign grp_carry[gi+1] = grp_g | (grp_p & grp_carry[gi]);
        assign sum[4*gi +: 4]  = p ^ c;
    end

    always_comb begin
        out_d = {grp_carry[c_NGRP], sum};
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_d;
        end
    end

    assign bus.out = out_q;

`ifdef ADDER_ISODD_EN
    logic isOdd_d;
    logic isOdd_q;

    always_comb begin
        isOdd_d = bus.inA[0] ^ bus.inB[0];
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            isOdd_q <= 1'b0;
        end else begin
            isOdd_q <= isOdd_d;
        end
    end

    assign bus.isOdd = isOdd_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_adder.sv
// +---------------------------------------------------------------------------+
// | tb_adder : directed self-checking bench for adder (W=32 and W=4).         |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
`default_nettype none

module tb_adder;
    logic clk;
    logic rst_n;
    int   errors;
    int   checks;

    adder_if #(.W(32)) bus32 ();
    adder_if #(.W(4))  bus4  ();

    adder #(.W(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
    adder #(.W(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive operands at the falling edge, then sample 1ns after the next rising edge.
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic rn,
                         input logic [32:0] exp_sum, input logic exp_odd, input string tag);
        @(negedge clk);
        bus32.inA = a;
        bus32.inB = b;
        rst_n     = rn;
        @(posedge clk);
        #1;
        check(tag, {32'd0, bus32.out}, {32'd0, exp_sum});
`ifdef ADDER_ISODD_EN
        check({tag, "_odd"}, {64'd0, bus32.isOdd}, {64'd0, exp_odd});
`else
        if (exp_odd === 1'bx) $display("note: unexpected X parity for %s", tag);
`endif
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        rst_n     = 1'b0;
        bus32.inA = '0;
        bus32.inB = '0;
        bus4.inA  = '0;
        bus4.inB  = '0;

        apply(32'd5, 32'd6, 1'b0, 33'd0, 1'b0, "rst_edge1");
        check("rst_w4", {60'd0, bus4.out}, 65'd0);
        apply(32'd5, 32'd6, 1'b0, 33'd0, 1'b0, "rst_edge2");

        apply(32'd0, 32'd0, 1'b1, 33'd0,  1'b0, "sum_0_0");
        apply(32'd1, 32'd1, 1'b1, 33'd2,  1'b0, "sum_1_1");
        apply(32'd5, 32'd6, 1'b1, 33'd11, 1'b1, "sum_5_6");
        apply(32'd2, 32'd2, 1'b1, 33'd4,  1'b0, "sum_2_2");
        apply(32'd3, 32'd3, 1'b1, 33'd6,  1'b0, "sum_3_3");
        apply(32'd1, 32'd8, 1'b1, 33'd9,  1'b1, "sum_1_8");
        apply(32'd1, 32'd2, 1'b1, 33'd3,  1'b1, "sum_1_2");
        apply(32'd3, 32'd4, 1'b1, 33'd7,  1'b1, "sum_3_4");

        apply(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 33'h1_FFFF_FFFE, 1'b0, "ones_ones");
        apply(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 33'h1_0000_0000, 1'b0, "ones_one");
        apply(32'h0000_FFFF, 32'h0000_0001, 1'b1, 33'h0_0001_0000, 1'b0, "grp_ripple");
        apply(32'h1234_5678, 32'h8765_4321, 1'b1, 33'h0_9999_9999, 1'b1, "mixed");
        apply(32'd0, 32'd0, 1'b1, 33'd0, 1'b0, "zero_zero");

        // Hold: operands change at the falling edge, out must not move until the rising edge.
        apply(32'd1, 32'd8, 1'b1, 33'd9, 1'b1, "hold_pre");
        @(negedge clk);
        bus32.inA = 32'd3;
        bus32.inB = 32'd4;
        #1;
        check("hold_mid", {32'd0, bus32.out}, 65'd9);
        @(posedge clk);
        #1;
        check("hold_post", {32'd0, bus32.out}, 65'd7);

        apply(32'd5, 32'd6, 1'b1, 33'd11, 1'b1, "midrst_a");
        apply(32'd3, 32'd4, 1'b0, 33'd0,  1'b0, "midrst_b");
        apply(32'd1, 32'd8, 1'b1, 33'd9,  1'b1, "midrst_c");

        // Narrow build.
        @(negedge clk);
        bus4.inA = 4'hF;
        bus4.inB = 4'hF;
        @(posedge clk);
        #1;
        check("w4_ones_ones", {60'd0, bus4.out}, 65'h1E);
        @(negedge clk);
        bus4.inA = 4'hF;
        bus4.inB = 4'h1;
        @(posedge clk);
        #1;
        check("w4_ones_one", {60'd0, bus4.out}, 65'h10);
        @(negedge clk);
        bus4.inA = 4'h7;
        bus4.inB = 4'h8;
        @(posedge clk);
        #1;
        check("w4_7_8", {60'd0, bus4.out}, 65'h0F);
`ifdef ADDER_ISODD_EN
        check("w4_7_8_odd", {64'd0, bus4.isOdd}, 65'd1);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
